// File: rtl/morse_pkg.sv
// rtl/morse_pkg.sv - shared state, element and timing definitions for the Morse player
package morse_pkg;

    typedef enum logic [1:0] {
        IDLE,
        TONE,
        GAP,
        TRAIL
    } state_t;

    typedef enum logic {
        ELEM_DOT  = 1'b0,
        ELEM_DASH = 1'b1
    } elem_t;

    localparam logic [2:0] DOT_UNITS      = 3'd1;
    localparam logic [2:0] DASH_UNITS     = 3'd3;
    localparam logic [2:0] ELEM_GAP_UNITS = 3'd1;
    localparam logic [2:0] CHAR_GAP_UNITS = 3'd3;
    localparam logic [2:0] WORD_GAP_UNITS = 3'd7;

    function automatic logic [2:0] elem_units(input elem_t e);
        return (e == ELEM_DASH) ? DASH_UNITS : DOT_UNITS;
    endfunction

endpackage

// File: rtl/tone_gen.sv
// rtl/tone_gen.sv - half-period divider producing the dot/dash square wave
module tone_gen
    import morse_pkg::*;
#(
    parameter int unsigned DOT_HALF  = 50000,
    parameter int unsigned DASH_HALF = 100000
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  clr,
    input  logic  en,
    input  elem_t sel,
    output logic  beep
);

    localparam int unsigned HALF_MAX = (DOT_HALF > DASH_HALF) ? DOT_HALF : DASH_HALF;
    localparam int unsigned HW       = (HALF_MAX > 1) ? $clog2(HALF_MAX) : 1;

    logic [HW-1:0] cnt;
    logic [HW-1:0] half_last;

    assign half_last = (sel == ELEM_DASH) ? HW'(DASH_HALF - 1) : HW'(DOT_HALF - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            beep <= 1'b0;
        end else if (clr) begin
            cnt  <= '0;
            beep <= 1'b0;
        end else if (en) begin
            if (cnt == half_last) begin
                cnt  <= '0;
                beep <= ~beep;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/morse_player.sv
// rtl/morse_player.sv - plays one latched Morse character onto the buzzer with unit timing
module morse_player
    import morse_pkg::*;
#(
    parameter int unsigned UNIT_CYCLES = 5000000,
    parameter int unsigned MAX_LEN     = 6,
    parameter int unsigned DOT_HALF    = 50000,
    parameter int unsigned DASH_HALF   = 100000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sym_valid,
    output logic               sym_ready,
    input  logic [MAX_LEN-1:0] sym_pattern,
    input  logic [2:0]         sym_len,
    input  logic               word_gap,
    input  logic               abort,
    output logic               beep,
    output logic               tone_on,
    output logic               busy,
    output logic               done
);

    localparam int unsigned CW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;

    state_t             state;
    state_t             state_next;
    logic [CW-1:0]      cyc_cnt;
    logic [2:0]         unit_cnt;
    logic [2:0]         units_cur;
    logic [MAX_LEN-1:0] pat_r;
    logic [2:0]         len_r;
    logic               wg_r;
    logic [2:0]         idx;
    logic [2:0]         len_c;
    logic               accept;
    logic               unit_end;
    logic               state_last;
    logic               more_elems;
    elem_t              elem_cur;
    logic               beep_raw;

    assign sym_ready  = (state == IDLE) && !abort;
    assign accept     = sym_valid && sym_ready;
    assign len_c      = (sym_len > 3'(MAX_LEN)) ? 3'(MAX_LEN) : sym_len;
    assign elem_cur   = elem_t'(pat_r[idx]);
    assign more_elems = (idx != (len_r - 3'd1));
    assign unit_end   = (cyc_cnt == CW'(UNIT_CYCLES - 1));
    assign state_last = unit_end && (unit_cnt == (units_cur - 3'd1));

    always_comb begin
        units_cur = ELEM_GAP_UNITS;
        case (state)
            TONE:    units_cur = elem_units(elem_cur);
            GAP:     units_cur = ELEM_GAP_UNITS;
            TRAIL:   units_cur = wg_r ? WORD_GAP_UNITS : CHAR_GAP_UNITS;
            default: units_cur = ELEM_GAP_UNITS;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (accept) state_next = (len_c != 3'd0) ? TONE : TRAIL;
            TONE:  if (state_last) state_next = more_elems ? GAP : TRAIL;
            GAP:   if (state_last) state_next = TONE;
            TRAIL: if (state_last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (abort) state_next = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cyc_cnt  <= '0;
            unit_cnt <= '0;
            pat_r    <= '0;
            len_r    <= '0;
            wg_r     <= 1'b0;
            idx      <= '0;
            done     <= 1'b0;
        end else begin
            state <= state_next;
            done  <= (state == TRAIL) && state_last && !abort;
            // Counters restart on every state change so each state lasts exactly units*UNIT_CYCLES.
            if (state_next != state) begin
                cyc_cnt  <= '0;
                unit_cnt <= '0;
            end else if (state != IDLE) begin
                if (unit_end) begin
                    cyc_cnt  <= '0;
                    unit_cnt <= unit_cnt + 3'd1;
                end else begin
                    cyc_cnt <= cyc_cnt + 1'b1;
                end
            end
            if (accept) begin
                pat_r <= sym_pattern;
                len_r <= len_c;
                wg_r  <= word_gap;
                idx   <= '0;
            end else if ((state == GAP) && state_last && !abort) begin
                idx <= idx + 3'd1;
            end
        end
    end

    tone_gen #(
        .DOT_HALF  (DOT_HALF),
        .DASH_HALF (DASH_HALF)
    ) u_tone_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   ((state_next == TONE) && (state != TONE)),
        .en    (state == TONE),
        .sel   (elem_cur),
        .beep  (beep_raw)
    );

    assign tone_on = (state == TONE);
    assign busy    = (state != IDLE);
    assign beep    = beep_raw && tone_on;

endmodule

// File: doc/morse_player.md
Name: morse_player

Overview:
Sequences one Morse character at a time onto the buzzer output. Takes a dot/dash pattern over a valid/ready handshake and times dots, dashes, intra-character gaps and the trailing character or word gap in units of UNIT_CYCLES. Gates a square-wave tone with a distinct pitch for dot and dash. Sits between the decoder/playback logic and the buzzer pin.

Parameters:
UNIT_CYCLES, 5000000, clk cycles per Morse time unit (50 ms at 100 MHz); must be at least 2
MAX_LEN, 6, maximum elements per character
DOT_HALF, 50000, half-period in clk cycles of the dot tone (1 kHz)
DASH_HALF, 100000, half-period in clk cycles of the dash tone (500 Hz)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
sym_valid  in  1  character request
sym_ready  out  1  block can accept a character
sym_pattern  in  MAX_LEN  element bits; bit0 is played first; 1=dash, 0=dot
sym_len  in  3  element count, 0..MAX_LEN
word_gap  in  1  trailing gap is 7 units instead of 3
abort  in  1  stop playback immediately
beep  out  1  square wave to buzzer
tone_on  out  1  high while an element sounds
busy  out  1  high in any non-IDLE state
done  out  1  one-cycle pulse after the trailing gap completes

Behaviour:
- Reset: state=IDLE; beep, tone_on, busy and done are 0; sym_ready=1; all counters are 0.
- sym_ready = (state==IDLE) && !abort. Accept when sym_valid && sym_ready. Latch the pattern, the length and word_gap. Ignore input changes after accept.
- sym_len > MAX_LEN is clamped to MAX_LEN.
- States and transitions:
  - IDLE: on accept, go to TONE with element index 0 if len>0, else go to TRAIL (a space character).
  - TONE: tone_on=1. Duration is 1 unit for a dot, 3 units for a dash. Then go to GAP if more elements remain, else go to TRAIL.
  - GAP: 1 unit of silence, then increment the index and go to TONE.
  - TRAIL: silence for 3 units, or 7 if word_gap was latched. Then go to IDLE and pulse done.
- Timing:
  - Each state lasts exactly units*UNIT_CYCLES cycles.
  - The unit counter and unit count clear on every state entry.
  - tone_on rises the cycle after the handshake.
  - done is high in the first IDLE cycle. sym_ready is also high that cycle, so back-to-back accept is allowed.
- Tone generation:
  - The half-period counter and beep reset to 0 on each TONE entry.
  - beep toggles every DOT_HALF or DASH_HALF cycles, selected by the current element.
  - Outside TONE, beep=0.
- Abort:
  - Has priority over everything. The next cycle is IDLE with beep, tone_on and busy at 0, and no done pulse.
  - Abort asserted in IDLE blocks accept that cycle.
- Reset asserted mid-character returns the block to the reset state asynchronously.
- Counter widths come from $clog2 of their maxima. No wrap is permitted within a state.

Decomposition:
- morse_pkg holds:
  - the state enum (IDLE, TONE, GAP, TRAIL)
  - constants DOT_UNITS=1, DASH_UNITS=3, ELEM_GAP_UNITS=1, CHAR_GAP_UNITS=3, WORD_GAP_UNITS=7
  - an element-type typedef
- One sub-module, tone_gen:
  - Half-period divider with clk, rst_n, a sync clear, an enable and a half-period select.
  - Outputs beep.

Test Plan (UNIT_CYCLES=4, DOT_HALF=1, DASH_HALF=2, MAX_LEN=6):
- Reset with sym_valid=1 held -> all outputs 0, sym_ready=1; no accept until rst_n is released.
- 'A' (pattern 0b10, len 2, word_gap=0) -> tone_on for 4 cycles with beep toggling every cycle; 4 silent; tone_on for 12 cycles with beep toggling every 2 cycles; 12 silent; done on cycle 33 after accept.
- len=0 with word_gap=1 -> no tone_on at all; busy for 28 cycles; then done.
- Back-to-back 'E' then 'T' with sym_valid held -> second accept in the done cycle; 'T' tone_on starts on the next cycle.
- abort during the second element of 'A' -> next cycle IDLE with beep=0 and no done; a new request is accepted normally afterwards.
- sym_len=7 with pattern all dashes -> exactly 6 dashes played.
